// File: rtl/taxi_ctrl.sv
// Taxi meter trip controller: key/wheel edge detection, trip FSM, fare/distance/wait accounting.
// Ports: clk, reset (sync, high), control[2:0] {stop,wait,start}, dist_pulse, state, fare, distance, wait_sec, fare_upd. Option: WAIT_CHARGE_EN.
module taxi_ctrl #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BASE_FARE = 80,
  parameter int BASE_DIST = 30,
  parameter int UNIT_FARE = 2,
  parameter int WAIT_SEC  = 60,
  parameter int WAIT_FARE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  control,
  input  logic        dist_pulse,
  output logic [1:0]  state,
  output logic [13:0] fare,
  output logic [13:0] distance,
  output logic [15:0] wait_sec,
  output logic        fare_upd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [13:0] MAX_V  = 14'd9999;
  localparam logic [15:0] MAX_W  = 16'd9999;
  localparam logic [13:0] B_FARE = 14'(BASE_FARE);
  localparam logic [13:0] B_DIST = 14'(BASE_DIST);
  localparam logic [15:0] U_FARE = 16'(UNIT_FARE);
  localparam logic [15:0] W_FARE = 16'(WAIT_FARE);

  logic [2:0]  ctrl_q;
  logic        dp_q;
  logic [2:0]  key_ev;
  logic        dist_ev;
  logic [1:0]  state_n;
  logic        load;
  logic        dist_cnt;
  logic [13:0] dist_n;
  logic        dist_add;
  logic        wait_add;
  logic [15:0] fare_sum;
  logic [13:0] fare_sat;

  assign key_ev  = control & ~ctrl_q;
  assign dist_ev = dist_pulse & ~dp_q;

  // Highest-priority key event wins even if the current state ignores it.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    if (key_ev[2]) begin
      if (state == S_RUN || state == S_WAIT)
        state_n = S_STOP;
    end else if (key_ev[1]) begin
      if (state == S_RUN)
        state_n = S_WAIT;
      else if (state == S_WAIT)
        state_n = S_RUN;
    end else if (key_ev[0]) begin
      if (state == S_IDLE || state == S_STOP) begin
        state_n = S_RUN;
        load    = 1'b1;
      end else if (state == S_WAIT) begin
        state_n = S_RUN;
      end
    end
  end

  // Wheel edges count on the current state, so an edge coinciding
  // with a key that leaves RUN is still billed.
  assign dist_cnt = (state == S_RUN) && dist_ev;
  assign dist_n   = distance +
                    14'((dist_cnt && distance != MAX_V) ? 1 : 0);
  assign dist_add = dist_cnt && (dist_n > B_DIST);

`ifdef WAIT_CHARGE_EN
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int SW = (WAIT_SEC > 1) ? $clog2(WAIT_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] SEC_MAX = SW'(WAIT_SEC - 1);

  logic [PW-1:0] pre_q;
  logic [SW-1:0] sec_q;
  logic          in_wait;
  logic          pre_wrap;

  assign in_wait  = (state == S_WAIT);
  assign pre_wrap = in_wait && (pre_q == PRE_MAX);
  assign wait_add = pre_wrap && (sec_q == SEC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q    <= '0;
      sec_q    <= '0;
      wait_sec <= '0;
    end else if (load) begin
      pre_q    <= '0;
      sec_q    <= '0;
      wait_sec <= '0;
    end else if (in_wait) begin
      pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
      if (pre_wrap) begin
        sec_q <= wait_add ? '0 : sec_q + 1'b1;
        if (wait_sec != 16'hFFFF)
          wait_sec <= wait_sec + 16'd1;
      end
    end
  end
`else
  assign wait_add = 1'b0;
  assign wait_sec = '0;
`endif

  assign fare_sum = {2'b00, fare} +
                    (dist_add ? U_FARE : 16'd0) +
                    (wait_add ? W_FARE : 16'd0);
  assign fare_sat = (fare_sum > MAX_W) ? MAX_V : fare_sum[13:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      dp_q     <= 1'b0;
      state    <= S_IDLE;
      fare     <= '0;
      distance <= '0;
      fare_upd <= 1'b0;
    end else begin
      ctrl_q <= control;
      dp_q   <= dist_pulse;
      state  <= state_n;
      if (load) begin
        fare     <= B_FARE;
        distance <= '0;
        fare_upd <= 1'b1;
      end else begin
        fare     <= fare_sat;
        distance <= dist_n;
        fare_upd <= (fare_sat != fare);
      end
    end
  end

endmodule

// File: tb/tb_taxi_ctrl.sv
// Bench for taxi_ctrl: behavioural trip model, per-cycle compare, directed and random stimulus.
// Model follows the WAIT_CHARGE_EN build setting.
module tb_taxi_ctrl;

  localparam int CF = 4;
  localparam int BF = 80;
  localparam int BD = 30;
  localparam int UF = 2;
  localparam int WS = 3;
  localparam int WF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  control = 3'b000;
  logic        dist_pulse = 1'b0;
  logic [1:0]  state;
  logic [13:0] fare;
  logic [13:0] distance;
  logic [15:0] wait_sec;
  logic        fare_upd;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  bit cmp_en = 1'b0;

  taxi_ctrl #(
    .CLK_FREQ(CF), .BASE_FARE(BF), .BASE_DIST(BD),
    .UNIT_FARE(UF), .WAIT_SEC(WS), .WAIT_FARE(WF)
  ) dut (
    .clk(clk), .reset(reset), .control(control),
    .dist_pulse(dist_pulse), .state(state), .fare(fare),
    .distance(distance), .wait_sec(wait_sec),
    .fare_upd(fare_upd)
  );

  always #5 clk = ~clk;

  // Trip model: fare is a closed-form function of raw wheel
  // edges and total waiting cycles since the trip started.
  int       m_state = 0;
  longint   m_dc = 0;
  longint   m_wc = 0;
  bit       m_trip = 1'b0;
  logic [2:0] m_pc = 3'b000;
  logic     m_pd = 1'b0;
  int       m_fare = 0;
  bit       m_upd = 1'b0;

  function automatic int fare_of(bit trip, longint dc, longint wc);
    longint f;
    if (!trip) return 0;
    f = BF + UF * ((dc > BD) ? dc - BD : 0) + WF * (wc / (CF * WS));
    return (f > 9999) ? 9999 : int'(f);
  endfunction

  always @(posedge clk) begin
    logic [2:0] ev;
    logic dev;
    bit ld;
    int nf;
    if (reset) begin
      m_state = 0; m_dc = 0; m_wc = 0; m_trip = 0;
      m_pc = 0; m_pd = 0; m_fare = 0; m_upd = 0;
    end else begin
      ev = control & ~m_pc;
      dev = dist_pulse & ~m_pd;
      m_pc = control;
      m_pd = dist_pulse;
      ld = 0;
      if (m_state == 1 && dev) m_dc++;
`ifdef WAIT_CHARGE_EN
      if (m_state == 2) m_wc++;
`endif
      if (ev[2]) begin
        if (m_state == 1 || m_state == 2) m_state = 3;
      end else if (ev[1]) begin
        if (m_state == 1) m_state = 2;
        else if (m_state == 2) m_state = 1;
      end else if (ev[0]) begin
        if (m_state == 0 || m_state == 3) begin
          m_state = 1; ld = 1; m_trip = 1; m_dc = 0; m_wc = 0;
        end else if (m_state == 2) m_state = 1;
      end
      nf = fare_of(m_trip, m_dc, m_wc);
      m_upd = ld || (nf != m_fare);
      m_fare = nf;
    end
  end

  always @(negedge clk) begin
    int md, mw;
    if (cmp_en) begin
      md = (m_dc > 9999) ? 9999 : int'(m_dc);
      mw = int'(m_wc / CF);
      if (mw > 65535) mw = 65535;
      total++;
      if (state !== 2'(m_state) || fare !== 14'(m_fare) ||
          distance !== 14'(md) || wait_sec !== 16'(mw) ||
          fare_upd !== m_upd) begin
        bad++;
        $display("FAIL model t=%0t got st=%0d f=%0d d=%0d w=%0d u=%0b want st=%0d f=%0d d=%0d w=%0d u=%0b",
                 $time, state, fare, distance, wait_sec, fare_upd,
                 m_state, m_fare, md, mw, m_upd);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      if (fare_upd === 1'b1) upd_cnt++;
    end
  endtask

  task automatic pulse(int n);
    repeat (n) begin
      dist_pulse = 1'b1; step(1);
      dist_pulse = 1'b0; step(1);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    step(3);
    cmp_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_fare", int'(fare), 0);
    chk("rst_upd", int'(fare_upd), 0);

    reset = 1'b0; control = 3'b001; upd_cnt = 0;
    step(10);
    chk("start_state", int'(state), 1);
    chk("start_fare", int'(fare), 80);
    chk("start_upd_cnt", upd_cnt, 1);
    control = 3'b000; step(1);

    upd_cnt = 0;
    pulse(30);
    chk("dist30_fare", int'(fare), 80);
    chk("dist30_upd", upd_cnt, 0);
    pulse(5);
    chk("dist35", int'(distance), 35);
    chk("dist35_fare", int'(fare), 90);
    chk("dist35_upd", upd_cnt, 5);

    control = 3'b111; step(1);
    control = 3'b000; step(1);
    chk("all_keys_stop", int'(state), 3);
    chk("stop_hold_fare", int'(fare), 90);
    control = 3'b001; step(1);
    control = 3'b000; step(1);
    chk("restart_state", int'(state), 1);
    chk("restart_fare", int'(fare), 80);
    chk("restart_dist", int'(distance), 0);

    control = 3'b010; step(1);
    control = 3'b000;
    pulse(12);
    chk("wait_state", int'(state), 2);
    chk("wait_dist", int'(distance), 0);
`ifdef WAIT_CHARGE_EN
    chk("wait_sec", int'(wait_sec), 6);
    chk("wait_fare", int'(fare), 100);
`else
    chk("wait_sec", int'(wait_sec), 0);
    chk("wait_fare", int'(fare), 80);
`endif

    reset = 1'b1; step(1);
    chk("midwait_state", int'(state), 0);
    chk("midwait_fare", int'(fare), 0);
    chk("midwait_dist", int'(distance), 0);
    chk("midwait_ws", int'(wait_sec), 0);
    chk("midwait_upd", int'(fare_upd), 0);
    reset = 1'b0; step(1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)
        control[$urandom_range(0, 2)] ^= 1'b1;
      dist_pulse = ($urandom_range(0, 2) != 0) ? ~dist_pulse : dist_pulse;
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0; control = 3'b000; dist_pulse = 1'b0;

    reset = 1'b1; step(1);
    reset = 1'b0; control = 3'b001; step(1);
    control = 3'b000; step(1);
    upd_cnt = 0;
    pulse(5000);
    chk("sat_fare", int'(fare), 9999);
    chk("sat_dist", int'(distance), 5000);
    chk("sat_upd_cnt", upd_cnt, 4960);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/taxi_ctrl.md
TAXI_CTRL -- requirements
Module: taxi_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning clk cycles per second for the wait-time tick.
REQ-002 The block SHALL have parameter BASE_FARE, default 80, meaning start fare in 0.1-yuan units.
REQ-003 The block SHALL have parameter BASE_DIST, default 30, meaning distance in 0.1-km units covered by the start fare.
REQ-004 The block SHALL have parameter UNIT_FARE, default 2, meaning fare added per 0.1 km beyond BASE_DIST.
REQ-005 The block SHALL have parameter WAIT_SEC, default 60, meaning wait seconds per wait charge; WAIT_FARE, default 10, meaning fare added per charge.
REQ-006 The block SHALL have port clk, input, 1, system clock; one clock domain, all logic on rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port control, input, 3, debounced active-high key levels: bit0 start, bit1 wait, bit2 stop.
REQ-009 The block SHALL have port dist_pulse, input, 1, synchronized wheel sensor level; each rising edge is 0.1 km.
REQ-010 The block SHALL have port state, output, 2, trip state: IDLE=0, RUN=1, WAIT=2, STOP=3.
REQ-011 The block SHALL have ports fare (14), distance (14) and wait_sec (16), outputs, fare in 0.1 yuan, distance in 0.1 km, total wait seconds.
REQ-012 The block SHALL have port fare_upd, output, 1, one-cycle pulse on every fare change.

Function
REQ-013 The block SHALL register control and dist_pulse each cycle; an event is input high while registered copy low (rising edge); held levels SHALL produce exactly one event.
REQ-014 An event detected in cycle n SHALL update state, fare, distance and fare_upd at the clock edge ending cycle n (visible cycle n+1).
REQ-015 Simultaneous key events SHALL resolve by priority stop > wait > start; lower-priority events that cycle SHALL be discarded.
REQ-016 IDLE: start -> RUN, load fare=BASE_FARE, clear distance, wait_sec, prescaler and second counter, pulse fare_upd; wait and stop ignored.
REQ-017 RUN: wait -> WAIT; stop -> STOP; start ignored.
REQ-018 WAIT: wait or start -> RUN; stop -> STOP.
REQ-019 STOP: start -> RUN as a new trip with the same load as REQ-016; wait and stop ignored; fare, distance, wait_sec held.
REQ-020 dist_pulse events SHALL be counted only in RUN: distance+1; if the new distance exceeds BASE_DIST, fare += UNIT_FARE and fare_upd pulses.
REQ-021 A dist_pulse event coincident with a key event leaving RUN SHALL still be counted.
REQ-022 distance SHALL saturate at 9999; fare SHALL saturate at 9999 (no wrap); fare_upd SHALL NOT pulse when fare is already 9999.
REQ-023 wait_sec SHALL saturate at 65535.

Reset
REQ-024 With reset high at a clock edge: state=IDLE, fare=0, distance=0, wait_sec=0, fare_upd=0, edge registers, prescaler and second counter cleared.
REQ-025 Edge registers SHALL reset to 0, so a key held high through reset release produces one event on the first cycle after release.
REQ-026 Reset mid-trip SHALL abandon the trip with no further fare_upd pulse.

Configuration
REQ-027 Macro WAIT_CHARGE_EN defined: prescaler counts 0..CLK_FREQ-1 only in WAIT; on wrap wait_sec+1 and second counter+1; when second counter reaches WAIT_SEC it clears, fare += WAIT_FARE, fare_upd pulses; partial counts persist across WAIT episodes within a trip.
REQ-028 Macro WAIT_CHARGE_EN undefined: prescaler and second counter absent, wait_sec tied 0, WAIT only suspends distance counting; all other behaviour unchanged.

Verification (CLK_FREQ=4, WAIT_SEC=3, other defaults)
REQ-029 Reset, control=001 held 10 cycles -> state=1, fare=80, exactly one fare_upd.
REQ-030 RUN, 35 dist_pulse edges -> distance=35, fare=90; 5 fare_upd pulses, on edges 31..35.
REQ-031 RUN, control=111 in one cycle -> state=3; then control=001 -> state=1, fare=80, distance=0.
REQ-032 WAIT_CHARGE_EN, RUN fare=80, wait key, hold 24 cycles -> wait_sec=6, fare=100; dist_pulse edges in WAIT leave distance unchanged.
REQ-033 fare forced near limit via 5000 dist_pulse edges -> fare=9999, distance=5000, no wrap, fare_upd stops at saturation.
REQ-034 Reset asserted mid-WAIT -> next cycle all outputs 0, state=0.
